// File: rtl/sopc_rst_seq.sv
// Power-on reset sequencer: holds all domains in reset, releases them one by one
// at a fixed stagger, then runs until halted or the cycle budget expires.
module sopc_rst_seq #(
    parameter int NUM_DOM     = 2,
    parameter int HOLD_CYC    = 10,
    parameter int STAGGER_CYC = 4,
    parameter int RUN_LIMIT   = 50,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   cyc_cnt,
    output logic               done,
    output logic               timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam int TMR_MAX = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_e             state_q, state_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W:0]     cyc_inc;
    logic [NUM_DOM-1:0] dom_next;

    always_comb begin
        state_d   = state_q;
        dom_rst_d = dom_rst_q;
        cyc_cnt_d = cyc_cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        tmr_d     = tmr_q;
        cyc_inc   = {1'b0, cyc_cnt_q} + 1'b1;
        // Domains release lowest index first, so each release is a left shift.
        dom_next  = dom_rst_q << 1;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                dom_rst_d = '1;
                if (start) begin
                    state_d   = S_HOLD;
                    cyc_cnt_d = '0;
                    tmr_d     = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_HOLD, S_RELEASE: begin
                if (halt_req) begin
                    state_d   = S_DONE;
                    dom_rst_d = '1;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if ((state_q == S_HOLD    && tmr_q == TMR_W'(HOLD_CYC - 1)) ||
                             (state_q == S_RELEASE && tmr_q == TMR_W'(STAGGER_CYC - 1))) begin
                    dom_rst_d = dom_next;
                    tmr_d     = '0;
                    state_d   = (dom_next == '0) ? S_RUN : S_RELEASE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d   = S_DONE;
                    dom_rst_d = '1;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (RUN_LIMIT != 0 && cyc_inc == (CNT_W+1)'(RUN_LIMIT)) begin
                    state_d   = S_DONE;
                    dom_rst_d = '1;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    cyc_cnt_d = cyc_inc[CNT_W-1:0];
                end else if (cyc_cnt_q != '1) begin
                    cyc_cnt_d = cyc_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_d   = S_IDLE;
                dom_rst_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            dom_rst_q <= '1;
            cyc_cnt_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            dom_rst_q <= dom_rst_d;
            cyc_cnt_q <= cyc_cnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            tmr_q     <= tmr_d;
        end
    end

    assign state   = state_q;
    assign dom_rst = dom_rst_q;
    assign cyc_cnt = cyc_cnt_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sopc_rst_seq.sv
// Bench for sopc_rst_seq: vector table, hand-written reset/saturation sequences,
// and random traffic against a time-since-start reference model.
module tb_sopc_rst_seq;

    localparam int NUM_DOM     = 2;
    localparam int HOLD_CYC    = 10;
    localparam int STAGGER_CYC = 4;
    localparam int RUN_LIMIT   = 50;
    localparam int CNT_W       = 16;
    localparam int T_RUN       = HOLD_CYC + (NUM_DOM - 1) * STAGGER_CYC;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic halt_req = 1'b0;

    logic [NUM_DOM-1:0] dom_rst;
    logic [2:0]         state;
    logic [CNT_W-1:0]   cyc_cnt;
    logic               done, timeout;

    logic [0:0] dom_rst2;
    logic [2:0] state2;
    logic [3:0] cyc_cnt2;
    logic       done2, timeout2;

    sopc_rst_seq #(.NUM_DOM(NUM_DOM), .HOLD_CYC(HOLD_CYC), .STAGGER_CYC(STAGGER_CYC),
                   .RUN_LIMIT(RUN_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .dom_rst(dom_rst), .state(state), .cyc_cnt(cyc_cnt), .done(done), .timeout(timeout)
    );

    // Single domain, no run limit, narrow counter: exercises direct HOLD->RUN and saturation.
    sopc_rst_seq #(.NUM_DOM(1), .HOLD_CYC(2), .STAGGER_CYC(1), .RUN_LIMIT(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .dom_rst(dom_rst2), .state(state2), .cyc_cnt(cyc_cnt2), .done(done2), .timeout(timeout2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle, 1=active (HOLD/RELEASE/RUN by elapsed time), 2=done.
    int m_phase = 0;
    int m_t     = 0;
    int m_cyc   = 0;
    int m_done  = 0;
    int m_to    = 0;

    function automatic int exp_state();
        if (m_phase == 0) return 0;
        if (m_phase == 2) return 4;
        if (m_t < HOLD_CYC) return 1;
        if (m_t < T_RUN) return 2;
        return 3;
    endfunction

    function automatic logic [NUM_DOM-1:0] exp_dom();
        logic [NUM_DOM-1:0] d;
        int rel;
        d = '1;
        if (m_phase != 1 || m_t < HOLD_CYC) return d;
        rel = (m_t - HOLD_CYC) / STAGGER_CYC + 1;
        if (rel > NUM_DOM) rel = NUM_DOM;
        for (int i = 0; i < rel; i++) d[i] = 1'b0;
        return d;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_cyc = 0; m_done = 0; m_to = 0;
    endtask

    task automatic model_step(input logic s, input logic h);
        if (m_phase != 1) begin
            if (s) begin
                m_phase = 1; m_t = 0; m_cyc = 0; m_done = 0; m_to = 0;
            end
        end else if (h) begin
            m_phase = 2; m_done = 1; m_to = 0;
        end else if (m_t >= T_RUN) begin
            if (RUN_LIMIT != 0 && m_cyc + 1 == RUN_LIMIT) begin
                m_cyc = m_cyc + 1; m_phase = 2; m_done = 1; m_to = 1;
            end else if (m_cyc < CNT_MAX) begin
                m_cyc = m_cyc + 1;
            end
        end else begin
            m_t = m_t + 1;
        end
    endtask

    task automatic compare_model();
        check("model.state",   32'(state),   exp_state());
        check("model.dom_rst", 32'(dom_rst), 32'(exp_dom()));
        check("model.cyc_cnt", 32'(cyc_cnt), m_cyc);
        check("model.done",    32'(done),    m_done);
        check("model.timeout", 32'(timeout), m_to);
    endtask

    task automatic step(input logic s, input logic h);
        @(negedge clk);
        start    = s;
        halt_req = h;
        @(posedge clk);
        model_step(s, h);
        #1;
        compare_model();
    endtask

    task automatic async_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        compare_model();
        #2;
        rst = 1'b1;
    endtask

    typedef struct {
        logic       st;
        logic       ht;
        int         n;
        logic [2:0] e_state;
        logic [1:0] e_dom;
        int         e_cyc;
        logic       e_done;
        logic       e_to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic ht, int n, logic [2:0] es, logic [1:0] ed,
                                int ec, logic edn, logic eto);
        vec_t v;
        v.st = st; v.ht = ht; v.n = n; v.e_state = es; v.e_dom = ed;
        v.e_cyc = ec; v.e_done = edn; v.e_to = eto;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Timeout run, then restart from DONE, halt at 20, halt coincident with limit,
        // start ignored while active, halt in RELEASE and in HOLD.
        tbl.push_back(mk(1, 0, 1,  3'd1, 2'b11, 0,  0, 0));
        tbl.push_back(mk(0, 0, 9,  3'd1, 2'b11, 0,  0, 0));
        tbl.push_back(mk(0, 0, 1,  3'd2, 2'b10, 0,  0, 0));
        tbl.push_back(mk(0, 0, 3,  3'd2, 2'b10, 0,  0, 0));
        tbl.push_back(mk(0, 0, 1,  3'd3, 2'b00, 0,  0, 0));
        tbl.push_back(mk(0, 0, 49, 3'd3, 2'b00, 49, 0, 0));
        tbl.push_back(mk(0, 0, 1,  3'd4, 2'b11, 50, 1, 1));
        tbl.push_back(mk(0, 1, 3,  3'd4, 2'b11, 50, 1, 1));
        tbl.push_back(mk(1, 0, 1,  3'd1, 2'b11, 0,  0, 0));
        tbl.push_back(mk(0, 0, 9,  3'd1, 2'b11, 0,  0, 0));
        tbl.push_back(mk(0, 0, 1,  3'd2, 2'b10, 0,  0, 0));
        tbl.push_back(mk(0, 0, 4,  3'd3, 2'b00, 0,  0, 0));
        tbl.push_back(mk(0, 0, 20, 3'd3, 2'b00, 20, 0, 0));
        tbl.push_back(mk(0, 1, 1,  3'd4, 2'b11, 20, 1, 0));
        tbl.push_back(mk(1, 0, 1,  3'd1, 2'b11, 0,  0, 0));
        tbl.push_back(mk(0, 0, 14, 3'd3, 2'b00, 0,  0, 0));
        tbl.push_back(mk(0, 0, 49, 3'd3, 2'b00, 49, 0, 0));
        tbl.push_back(mk(0, 1, 1,  3'd4, 2'b11, 49, 1, 0));
        tbl.push_back(mk(1, 0, 1,  3'd1, 2'b11, 0,  0, 0));
        tbl.push_back(mk(1, 0, 9,  3'd1, 2'b11, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1,  3'd2, 2'b10, 0,  0, 0));
        tbl.push_back(mk(0, 1, 1,  3'd4, 2'b11, 0,  1, 0));
        tbl.push_back(mk(1, 0, 1,  3'd1, 2'b11, 0,  0, 0));
        tbl.push_back(mk(0, 1, 1,  3'd4, 2'b11, 0,  1, 0));
        tbl.push_back(mk(0, 0, 5,  3'd4, 2'b11, 0,  1, 0));

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        check("rst.state2", 32'(state2), 0);
        check("rst.dom2",   32'(dom_rst2), 1);
        @(negedge clk);
        rst = 1'b1;

        // Single domain skips RELEASE; unlimited counter saturates without wrapping.
        step(1'b1, 1'b0);
        check("d2.hold.state", 32'(state2), 1);
        check("d2.hold.dom",   32'(dom_rst2), 1);
        step(1'b0, 1'b0);
        check("d2.hold2.state", 32'(state2), 1);
        step(1'b0, 1'b0);
        check("d2.run.state", 32'(state2), 3);
        check("d2.run.dom",   32'(dom_rst2), 0);
        check("d2.run.cyc",   32'(cyc_cnt2), 0);
        repeat (15) step(1'b0, 1'b0);
        check("d2.sat15.cyc", 32'(cyc_cnt2), 15);
        repeat (5) step(1'b0, 1'b0);
        check("d2.sat20.cyc",   32'(cyc_cnt2), 15);
        check("d2.sat20.state", 32'(state2), 3);
        step(1'b0, 1'b1);
        check("d2.halt.state", 32'(state2), 4);
        check("d2.halt.cyc",   32'(cyc_cnt2), 15);
        check("d2.halt.to",    32'(timeout2), 0);
        check("d2.halt.done",  32'(done2), 1);

        // Table vectors from a fresh reset
        async_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].st, tbl[i].ht);
            check($sformatf("vec%0d.state", i),   32'(state),   32'(tbl[i].e_state));
            check($sformatf("vec%0d.dom_rst", i), 32'(dom_rst), 32'(tbl[i].e_dom));
            check($sformatf("vec%0d.cyc_cnt", i), 32'(cyc_cnt), tbl[i].e_cyc);
            check($sformatf("vec%0d.done", i),    32'(done),    32'(tbl[i].e_done));
            check($sformatf("vec%0d.timeout", i), 32'(timeout), 32'(tbl[i].e_to));
        end

        // Asynchronous reset in the middle of RELEASE, then no auto-start
        async_reset();
        step(1'b1, 1'b0);
        repeat (11) step(1'b0, 1'b0);
        check("midrel.state", 32'(state), 2);
        check("midrel.dom",   32'(dom_rst), 2);
        async_reset();
        check("arst.state", 32'(state), 0);
        check("arst.dom",   32'(dom_rst), 3);
        repeat (5) step(1'b0, 1'b0);
        check("noauto.state", 32'(state), 0);
        check("noauto.dom",   32'(dom_rst), 3);

        // Random traffic against the model, with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            else step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
